// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage bus sequencer for the 5-stage MIPS pipeline.
//   Converts an ex-stage load/store into one req/ack bus transaction.
//   Stalls the pipeline until the transaction completes.
//   Returns load data to the writeback mux.
//   If no ack arrives within TIMEOUT request cycles, the access is aborted with a
//   one-cycle me_BusErr pulse instead of deadlocking the pipe.
// Ports:
//   clk, reset                sync active-high reset
//   ex_MemRd/ex_MemWr         load/store request, held while me_Stall=1
//   ex_Addr/WrData/ByteEn     access attributes, latched on IDLE->REQ
//   ext_Req/We/Addr/WrData/ByteEn   registered bus request side
//   ext_Ack/ext_RdData        bus completion and read data
//   me_ExtMemRdData           captured load data (0 after a timeout)
//   me_Stall                  pipeline freeze (combinational)
//   me_BusErr                 timeout pulse, high only in ERR
module mem_access_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_MemRd,
  input  logic        ex_MemWr,
  input  logic [31:0] ex_Addr,
  input  logic [31:0] ex_WrData,
  input  logic [3:0]  ex_ByteEn,
  output logic        ext_Req,
  output logic        ext_We,
  output logic [31:0] ext_Addr,
  output logic [31:0] ext_WrData,
  output logic [3:0]  ext_ByteEn,
  input  logic        ext_Ack,
  input  logic [31:0] ext_RdData,
  output logic [31:0] me_ExtMemRdData,
  output logic        me_Stall,
  output logic        me_BusErr
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             exReq;

  assign exReq = ex_MemRd | ex_MemWr;

  // DONE/ERR deliberately drop stall: the pipe advances while ex_* still shows
  // the finished instruction, so those states must not re-accept it.
  assign me_Stall = ((state == IDLE) && exReq) || (state == REQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      ext_Req         <= 1'b0;
      ext_We          <= 1'b0;
      ext_Addr        <= 32'h0;
      ext_WrData      <= 32'h0;
      ext_ByteEn      <= 4'h0;
      me_ExtMemRdData <= 32'h0;
      me_BusErr       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (exReq) begin
            state      <= REQ;
            ext_Req    <= 1'b1;
            // read wins when both are asserted
            ext_We     <= ex_MemWr & ~ex_MemRd;
            ext_Addr   <= ex_Addr;
            ext_WrData <= ex_WrData;
            ext_ByteEn <= ex_ByteEn;
            cnt        <= '0;
          end
        end
        REQ: begin
          // ack takes priority over a timeout in the same cycle
          if (ext_Ack) begin
            state   <= DONE;
            ext_Req <= 1'b0;
            if (!ext_We) me_ExtMemRdData <= ext_RdData;
          end else if (cnt == LAST_CNT) begin
            state           <= ERR;
            ext_Req         <= 1'b0;
            me_BusErr       <= 1'b1;
            me_ExtMemRdData <= 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        ERR: begin
          state     <= IDLE;
          me_BusErr <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          ext_Req   <= 1'b0;
          me_BusErr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT=15).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_MemRd, ex_MemWr;
  logic [31:0] ex_Addr, ex_WrData;
  logic [3:0]  ex_ByteEn;
  logic        ext_Req, ext_We;
  logic [31:0] ext_Addr, ext_WrData;
  logic [3:0]  ext_ByteEn;
  logic        ext_Ack;
  logic [31:0] ext_RdData;
  logic [31:0] me_ExtMemRdData;
  logic        me_Stall, me_BusErr;

  int nVec = 0;
  int nMis = 0;
  int stallCyc, reqCyc, errCyc;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .ex_MemRd(ex_MemRd), .ex_MemWr(ex_MemWr), .ex_Addr(ex_Addr),
    .ex_WrData(ex_WrData), .ex_ByteEn(ex_ByteEn),
    .ext_Req(ext_Req), .ext_We(ext_We), .ext_Addr(ext_Addr),
    .ext_WrData(ext_WrData), .ext_ByteEn(ext_ByteEn),
    .ext_Ack(ext_Ack), .ext_RdData(ext_RdData),
    .me_ExtMemRdData(me_ExtMemRdData), .me_Stall(me_Stall), .me_BusErr(me_BusErr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present an access from IDLE and run until stall drops (DONE or ERR).
  // Ack is raised on the ackAt-th REQ cycle (0 = never). Bounded at 50 cycles.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int ackAt, input logic [31:0] rdData);
    ex_MemRd = rd; ex_MemWr = wr; ex_Addr = addr; ex_WrData = wdata; ex_ByteEn = be;
    ext_Ack = 1'b0;
    #1;
    stallCyc = 0; reqCyc = 0; errCyc = 0;
    for (int i = 0; i < 50; i++) begin
      if (!me_Stall) break;
      stallCyc++;
      if (ext_Req) begin
        reqCyc++;
        ext_Ack    = (reqCyc == ackAt);
        ext_RdData = rdData;
      end
      @(posedge clk); #1;
      ext_Ack = 1'b0;
      #1;
      if (me_BusErr) errCyc++;
    end
  endtask

  task automatic release_ex();
    ex_MemRd = 1'b0; ex_MemWr = 1'b0; ext_Ack = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; ex_MemRd = 0; ex_MemWr = 0; ex_Addr = 0; ex_WrData = 0; ex_ByteEn = 0;
    ext_Ack = 0; ext_RdData = 0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_req",    {31'b0, ext_Req}, 32'h0);
    chk("rst_stall",  {31'b0, me_Stall}, 32'h0);
    chk("rst_data",   me_ExtMemRdData, 32'h0);
    chk("rst_buserr", {31'b0, me_BusErr}, 32'h0);

    // 1: load, ack on first REQ cycle
    access(1, 0, 32'h100, 32'h0, 4'hF, 1, 32'hCAFEF00D);
    chk("t1_stall",   stallCyc, 2);
    chk("t1_reqcyc",  reqCyc, 1);
    chk("t1_data",    me_ExtMemRdData, 32'hCAFEF00D);
    chk("t1_we",      {31'b0, ext_We}, 32'h0);
    chk("t1_addr",    ext_Addr, 32'h100);
    chk("t1_reqdone", {31'b0, ext_Req}, 32'h0);
    release_ex();

    // 2: store, ack on 4th REQ cycle; read data must survive
    access(0, 1, 32'h204, 32'h12345678, 4'b0011, 4, 32'hDEADBEEF);
    chk("t2_stall",  stallCyc, 5);
    chk("t2_reqcyc", reqCyc, 4);
    chk("t2_addr",   ext_Addr, 32'h204);
    chk("t2_wdata",  ext_WrData, 32'h12345678);
    chk("t2_be",     {28'b0, ext_ByteEn}, 32'h3);
    chk("t2_we",     {31'b0, ext_We}, 32'h1);
    chk("t2_data",   me_ExtMemRdData, 32'hCAFEF00D);
    release_ex();

    // 3: load with no ack -> timeout
    access(1, 0, 32'h300, 32'h0, 4'hF, 0, 32'h11111111);
    chk("t3_reqcyc", reqCyc, 15);
    chk("t3_stall",  stallCyc, 16);
    chk("t3_errcyc", errCyc, 1);
    chk("t3_data",   me_ExtMemRdData, 32'h0);
    release_ex();
    chk("t3_errgone", {31'b0, me_BusErr}, 32'h0);

    // 4: ack on the last allowed REQ cycle wins over timeout
    access(1, 0, 32'h310, 32'h0, 4'hF, 15, 32'h5A5A0F0F);
    chk("t4_reqcyc", reqCyc, 15);
    chk("t4_errcyc", errCyc, 0);
    chk("t4_data",   me_ExtMemRdData, 32'h5A5A0F0F);
    release_ex();
    // stray ack in IDLE
    ext_Ack = 1'b1; ext_RdData = 32'hBAADBAAD;
    step(); step();
    chk("t4_stray_req",   {31'b0, ext_Req}, 32'h0);
    chk("t4_stray_stall", {31'b0, me_Stall}, 32'h0);
    chk("t4_stray_data",  me_ExtMemRdData, 32'h5A5A0F0F);
    ext_Ack = 1'b0;
    step();

    // 5: rd and wr both set -> read
    access(1, 1, 32'h400, 32'hFFFF0000, 4'hF, 2, 32'h01020304);
    chk("t5_we",    {31'b0, ext_We}, 32'h0);
    chk("t5_data",  me_ExtMemRdData, 32'h01020304);
    chk("t5_stall", stallCyc, 3);
    // back-to-back: next load presented during DONE
    ex_MemRd = 1; ex_MemWr = 0; ex_Addr = 32'h408; #1;
    chk("t5_b2b_done_stall", {31'b0, me_Stall}, 32'h0);
    step();
    access(1, 0, 32'h408, 32'h0, 4'hF, 1, 32'h0A0B0C0D);
    chk("t5_b2b_stall", stallCyc, 2);
    chk("t5_b2b_addr",  ext_Addr, 32'h408);
    chk("t5_b2b_data",  me_ExtMemRdData, 32'h0A0B0C0D);
    release_ex();

    // 6: reset on the 3rd REQ cycle of a store
    ex_MemRd = 0; ex_MemWr = 1; ex_Addr = 32'h500; ex_WrData = 32'hA5A5A5A5; ex_ByteEn = 4'hF;
    step(); step(); step();
    chk("t6_pre_req", {31'b0, ext_Req}, 32'h1);
    chk("t6_pre_we",  {31'b0, ext_We}, 32'h1);
    reset = 1'b1;
    step();
    ex_MemWr = 0; #1;
    chk("t6_req",   {31'b0, ext_Req}, 32'h0);
    chk("t6_we",    {31'b0, ext_We}, 32'h0);
    chk("t6_addr",  ext_Addr, 32'h0);
    chk("t6_wdata", ext_WrData, 32'h0);
    chk("t6_be",    {28'b0, ext_ByteEn}, 32'h0);
    chk("t6_data",  me_ExtMemRdData, 32'h0);
    chk("t6_err",   {31'b0, me_BusErr}, 32'h0);
    chk("t6_stall", {31'b0, me_Stall}, 32'h0);
    reset = 1'b0;
    step();
    // back in IDLE: a fresh load completes normally
    access(1, 0, 32'h600, 32'h0, 4'hF, 1, 32'h77778888);
    chk("t6_after_stall", stallCyc, 2);
    chk("t6_after_data",  me_ExtMemRdData, 32'h77778888);
    release_ex();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
